digit_overlay_gen: RTL and testbench
====================================

DIGIT_OVERLAY_GEN -- requirements
Module: digit_overlay_gen

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, meaning the number of decimal digit fields drawn side by side (1..8).
REQ-002 SHALL have parameter GLYPH_W, default 32, meaning the glyph width in pixels.
REQ-003 SHALL have parameter GLYPH_H, default 32, meaning the glyph height in pixels.
REQ-004 SHALL have parameter X0, default 400, meaning the left pixel column of the leftmost field.
REQ-005 SHALL have parameter Y0, default 40, meaning the top pixel row of all fields.
REQ-006 SHALL have parameter BLINK_FRAMES, default 30, meaning the number of frames per blink half-period.
REQ-007 SHALL have parameter ADDR_W, default 12, meaning the glyph ROM address width.
REQ-008 SHALL have port clka, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have ports h_cnt and v_cnt, input, 10 bits each: the current scan position.
REQ-011 SHALL have port base_pixel, input, 12 bits: the underlying RGB444 pixel for the current h_cnt/v_cnt.
REQ-012 SHALL have port value, input, 4*N_DIGITS bits: BCD digits; the top nibble is the leftmost field.
REQ-013 SHALL have port digit_color, input, 12*N_DIGITS bits: per-field foreground colour, indexed like value.
REQ-014 SHALL have port blink_mask, input, N_DIGITS bits: set bits mark fields that blink.
REQ-015 SHALL have port lz_suppress, input, 1 bit: enables leading-zero blanking.
REQ-016 SHALL have port load, input, 1 bit: request to capture value, digit_color, blink_mask and lz_suppress.
REQ-017 SHALL have port busy, output, 1 bit: a load is pending until the next frame start.
REQ-018 SHALL have port glyph_addr, output, ADDR_W bits: the address to an external 10-glyph ROM bank.
REQ-019 SHALL have port glyph_bits, input, 10 bits: bit k is the glyph-k pixel, valid 1 cycle after glyph_addr.
REQ-020 SHALL have port pixel_out, output, 12 bits: the composited pixel.

Function
REQ-021 SHALL detect frame start as the first clka cycle in which h_cnt==0 and v_cnt==0 after a cycle in which that condition was false.
REQ-022 SHALL hold a load request as pending with busy=1, and SHALL copy all four captured inputs into shadow registers at the next frame start, clearing busy in the same cycle.
REQ-023 SHALL, when load is asserted during a frame-start cycle, commit the new inputs at that same frame start.
REQ-024 SHALL, when load is asserted again while a load is pending, overwrite the captured inputs, so the last request wins.
REQ-025 SHALL keep a frame counter that increments at each frame start and wraps to 0 at BLINK_FRAMES-1, toggling blink_phase on that wrap.
REQ-026 SHALL treat field i as hit when X0+i'*GLYPH_W <= h_cnt < X0+(i'+1)*GLYPH_W and Y0 <= v_cnt < Y0+GLYPH_H, where i' = N_DIGITS-1-i is the field's slot counted from the left.
REQ-027 SHALL form the address as (v_cnt-Y0)*GLYPH_W + (h_cnt-X0-i'*GLYPH_W), truncated to ADDR_W bits, and SHALL register it onto glyph_addr.
REQ-028 SHALL register glyph_addr to 0 when no field is hit.
REQ-029 SHALL use a fixed 2-cycle pipeline: stage 1 registers the address, hit flag, field index, digit and base_pixel; stage 2 registers pixel_out.
REQ-030 SHALL make pixel_out correspond to the h_cnt/v_cnt/base_pixel presented 2 cycles earlier.
REQ-031 SHALL set pixel_out to the shadow digit_color of field i when the field is hit and drawable and glyph_bits[digit]=1; otherwise pixel_out SHALL equal the delayed base_pixel.
REQ-032 SHALL treat a field as not drawable when its digit is greater than 9.
REQ-033 SHALL treat a field as not drawable when its blink_mask bit is set and blink_phase=0.
REQ-034 SHALL treat a field as not drawable when lz_suppress=1, its digit is 0, all fields to its left are 0, and it is not field 0.
REQ-035 SHALL always draw field 0 when its digit is 9 or less, whatever the lz_suppress setting.
REQ-036 SHALL evaluate drawability from the shadow registers only, so a frame is never torn.

Reset
REQ-037 SHALL, while rst=1 at a clka edge, clear pixel_out, glyph_addr, busy, the frame counter, all shadow registers and the pipeline registers to 0, and set blink_phase to 1.
REQ-038 SHALL, when rst is asserted mid-frame, discard any pending load.
REQ-039 SHALL, after reset is released, have the frame-start detector treat the first cycle with h_cnt==0 and v_cnt==0 as a frame start.

Verification
REQ-040 SHALL cover load of value=16'h0123 with lz_suppress=1 mid-frame -> busy=1 until frame start; next frame shows "123" with the leftmost field equal to base_pixel.
REQ-041 SHALL cover h_cnt=X0, v_cnt=Y0 on the leftmost field with glyph_bits=10'h3FF -> glyph_addr=0 one cycle later; pixel_out equal to that field's colour 2 cycles later.
REQ-042 SHALL cover blink_mask=4'b0001 with BLINK_FRAMES=2 -> field 0 drawn for frames 0-1, blank for frames 2-3, drawn again for frame 4.
REQ-043 SHALL cover two loads (0x1111 then 0x2222) before one frame start -> 0x2222 displayed and busy cleared at that frame start.
REQ-044 SHALL cover a digit nibble of 4'hA -> that field shows base_pixel throughout the frame.
REQ-045 SHALL cover rst asserted with busy=1 -> busy=0 and pixel_out=0 on the next edge; no commit at the following frame start.

Source files
------------

// File: rtl/digit_overlay_gen.sv
`default_nettype none
// ============================================================================
// digit_overlay_gen : overlays N_DIGITS BCD glyph fields on a video stream,
//                     with frame-aligned loading, blinking and zero blanking.
// Revision: 1.0
// ============================================================================
module digit_overlay_gen #(
    parameter int N_DIGITS     = 4,
    parameter int GLYPH_W      = 32,
    parameter int GLYPH_H      = 32,
    parameter int X0           = 400,
    parameter int Y0           = 40,
    parameter int BLINK_FRAMES = 30,
    parameter int ADDR_W       = 12
) (
    input  logic                   clka,
    input  logic                   rst,
    input  logic [9:0]             h_cnt,
    input  logic [9:0]             v_cnt,
    input  logic [11:0]            base_pixel,
    input  logic [4*N_DIGITS-1:0]  value,
    input  logic [12*N_DIGITS-1:0] digit_color,
    input  logic [N_DIGITS-1:0]    blink_mask,
    input  logic                   lz_suppress,
    input  logic                   load,
    output logic                   busy,
    output logic [ADDR_W-1:0]      glyph_addr,
    input  logic [9:0]             glyph_bits,
    output logic [11:0]            pixel_out
);
    localparam int VW  = 4 * N_DIGITS;
    localparam int CW  = 12 * N_DIGITS;
    localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);
    localparam logic [31:0]    Y_LO    = 32'(Y0);
    localparam logic [31:0]    Y_HI    = 32'(Y0 + GLYPH_H);

    logic              prev_zero_q, prev_zero_d;
    logic              busy_q, busy_d;
    logic [VW-1:0]     pend_value_q, pend_value_d, sh_value_q, sh_value_d;
    logic [CW-1:0]     pend_color_q, pend_color_d, sh_color_q, sh_color_d;
    logic [N_DIGITS-1:0] pend_mask_q, pend_mask_d, sh_mask_q, sh_mask_d;
    logic              pend_lz_q, pend_lz_d, sh_lz_q, sh_lz_d;
    logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              draw_q, draw_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [3:0]        digit_q, digit_d;
    logic [11:0]       base_q, base_d;
    logic [11:0]       pixel_q, pixel_d;

    logic              at_origin, frame_start, v_in, run, glyph_on;
    logic [31:0]       h_ext, v_ext;
    logic [N_DIGITS-1:0] field_hit, field_draw, zero_run;
    logic [ADDR_W-1:0] field_addr [N_DIGITS];
    logic              sel_hit, sel_draw;
    logic [IW-1:0]     sel_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        sel_digit;

    assign at_origin   = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign frame_start = at_origin && !prev_zero_q;
    assign h_ext       = {22'd0, h_cnt};
    assign v_ext       = {22'd0, v_cnt};
    assign v_in        = (v_ext >= Y_LO) && (v_ext < Y_HI);

    // zero_run[i] is set when field i and every field to its left hold 0
    always_comb begin
        zero_run = '0;
        run      = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run         = run & (sh_value_q[4*i +: 4] == 4'd0);
            zero_run[i] = run;
        end
    end

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_field
        localparam int          SLOT   = N_DIGITS - 1 - i;
        localparam logic [31:0] X_LO   = 32'(X0 + SLOT * GLYPH_W);
        localparam logic [31:0] X_HI   = 32'(X0 + (SLOT + 1) * GLYPH_W);
        localparam logic        IS_LSD = (i == 0);
        logic [3:0] dig;
        assign dig           = sh_value_q[4*i +: 4];
        assign field_hit[i]  = (h_ext >= X_LO) && (h_ext < X_HI) && v_in;
        assign field_addr[i] = ADDR_W'((v_ext - Y_LO) * GLYPH_W + (h_ext - X_LO));
        assign field_draw[i] = (dig <= 4'd9)
                             && !(sh_mask_q[i] && !blink_phase_q)
                             && !(sh_lz_q && zero_run[i] && !IS_LSD);
    end

    always_comb begin
        sel_hit   = 1'b0;
        sel_draw  = 1'b0;
        sel_idx   = '0;
        sel_addr  = '0;
        sel_digit = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (field_hit[i]) begin
                sel_hit   = 1'b1;
                sel_draw  = field_draw[i];
                sel_idx   = IW'(i);
                sel_addr  = field_addr[i];
                sel_digit = sh_value_q[4*i +: 4];
            end
        end
    end

    assign glyph_on = (digit_q <= 4'd9) ? glyph_bits[digit_q] : 1'b0;

    always_comb begin
        prev_zero_d   = at_origin;
        busy_d        = busy_q;
        pend_value_d  = pend_value_q;
        pend_color_d  = pend_color_q;
        pend_mask_d   = pend_mask_q;
        pend_lz_d     = pend_lz_q;
        sh_value_d    = sh_value_q;
        sh_color_d    = sh_color_q;
        sh_mask_d     = sh_mask_q;
        sh_lz_d       = sh_lz_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (load) begin
            pend_value_d = value;
            pend_color_d = digit_color;
            pend_mask_d  = blink_mask;
            pend_lz_d    = lz_suppress;
            busy_d       = 1'b1;
        end
        if (frame_start) begin
            busy_d = 1'b0;
            // A load arriving on the frame-start cycle bypasses the pending copy
            if (load) begin
                sh_value_d = value;
                sh_color_d = digit_color;
                sh_mask_d  = blink_mask;
                sh_lz_d    = lz_suppress;
            end else if (busy_q) begin
                sh_value_d = pend_value_q;
                sh_color_d = pend_color_q;
                sh_mask_d  = pend_mask_q;
                sh_lz_d    = pend_lz_q;
            end
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
            end
        end
        addr_d  = sel_hit ? sel_addr : '0;
        draw_d  = sel_hit && sel_draw;
        idx_d   = sel_idx;
        digit_d = sel_digit;
        base_d  = base_pixel;
        pixel_d = (draw_q && glyph_on) ? sh_color_q[12*idx_q +: 12] : base_q;
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            prev_zero_q   <= 1'b0;
            busy_q        <= 1'b0;
            pend_value_q  <= '0;
            pend_color_q  <= '0;
            pend_mask_q   <= '0;
            pend_lz_q     <= 1'b0;
            sh_value_q    <= '0;
            sh_color_q    <= '0;
            sh_mask_q     <= '0;
            sh_lz_q       <= 1'b0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            addr_q        <= '0;
            draw_q        <= 1'b0;
            idx_q         <= '0;
            digit_q       <= '0;
            base_q        <= '0;
            pixel_q       <= '0;
        end else begin
            prev_zero_q   <= prev_zero_d;
            busy_q        <= busy_d;
            pend_value_q  <= pend_value_d;
            pend_color_q  <= pend_color_d;
            pend_mask_q   <= pend_mask_d;
            pend_lz_q     <= pend_lz_d;
            sh_value_q    <= sh_value_d;
            sh_color_q    <= sh_color_d;
            sh_mask_q     <= sh_mask_d;
            sh_lz_q       <= sh_lz_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            addr_q        <= addr_d;
            draw_q        <= draw_d;
            idx_q         <= idx_d;
            digit_q       <= digit_d;
            base_q        <= base_d;
            pixel_q       <= pixel_d;
        end
    end

    assign busy       = busy_q;
    assign glyph_addr = addr_q;
    assign pixel_out  = pixel_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_overlay_gen.sv
`default_nettype none
// ============================================================================
// tb_digit_overlay_gen : scoreboard bench for the digit overlay generator.
// Revision: 1.0
// ============================================================================
module tb_digit_overlay_gen;
    localparam int N  = 4;
    localparam int GW = 32;
    localparam int GH = 32;
    localparam int X0 = 400;
    localparam int Y0 = 40;
    localparam int BF = 2;
    localparam int AW = 12;
    localparam logic [47:0] COLORS = {12'hF00, 12'h0F0, 12'h00F, 12'hFF0};

    logic        clka = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic [11:0] base_pixel;
    logic [15:0] value;
    logic [47:0] digit_color;
    logic [3:0]  blink_mask;
    logic        lz_suppress, load;
    logic        busy;
    logic [AW-1:0] glyph_addr;
    logic [9:0]  glyph_bits;
    logic [11:0] pixel_out;

    always #5 clka = ~clka;

    digit_overlay_gen #(
        .N_DIGITS(N), .GLYPH_W(GW), .GLYPH_H(GH), .X0(X0), .Y0(Y0),
        .BLINK_FRAMES(BF), .ADDR_W(AW)
    ) dut (
        .clka(clka), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .base_pixel(base_pixel), .value(value), .digit_color(digit_color),
        .blink_mask(blink_mask), .lz_suppress(lz_suppress), .load(load),
        .busy(busy), .glyph_addr(glyph_addr), .glyph_bits(glyph_bits),
        .pixel_out(pixel_out)
    );

    // Glyph ROM model: either a fixed pattern or an address hash
    logic       use_hash;
    logic [9:0] rom_const;
    function automatic logic [9:0] rom_hash(input logic [11:0] a);
        return 10'((a * 12'd41) ^ (a >> 5));
    endfunction
    always_comb glyph_bits = use_hash ? rom_hash(glyph_addr) : rom_const;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          h;
        int          v;
        logic [11:0] addr;
        logic [11:0] pix;
        bit          chk;
    } exp_t;
    exp_t sb[$];

    logic [15:0] m_value, p_value;
    logic [47:0] m_color, p_color;
    logic [3:0]  m_mask, p_mask;
    logic        m_lz, p_lz, m_busy, m_phase, m_prev;
    int          m_cnt;

    function automatic int fx(input int slot);
        return X0 + slot * GW;
    endfunction

    function automatic int field_at(input int h, input int v);
        int f;
        int xl;
        f = -1;
        for (int i = 0; i < N; i++) begin
            xl = fx(N - 1 - i);
            if (h >= xl && h < xl + GW && v >= Y0 && v < Y0 + GH) f = i;
        end
        return f;
    endfunction

    function automatic logic [11:0] exp_addr(input int h, input int v);
        int f;
        f = field_at(h, v);
        if (f < 0) return 12'h000;
        return 12'((v - Y0) * GW + (h - fx(N - 1 - f)));
    endfunction

    function automatic logic [11:0] exp_pix(input int h, input int v, input logic [11:0] base);
        int         f;
        logic [3:0] d;
        logic [9:0] bits;
        bit         lead;
        f = field_at(h, v);
        if (f < 0) return base;
        d = m_value[4*f +: 4];
        if (d > 4'd9) return base;
        if (m_mask[f] && !m_phase) return base;
        lead = 1'b1;
        for (int j = f; j < N; j++) if (m_value[4*j +: 4] != 4'd0) lead = 1'b0;
        if (m_lz && lead && f != 0) return base;
        bits = use_hash ? rom_hash(exp_addr(h, v)) : rom_const;
        return bits[d] ? m_color[12*f +: 12] : base;
    endfunction

    function automatic void model_update(input int h, input int v);
        bit origin;
        bit fs;
        origin = (h == 0 && v == 0);
        if (rst) begin
            m_value = '0; m_color = '0; m_mask = '0; m_lz = 1'b0;
            p_value = '0; p_color = '0; p_mask = '0; p_lz = 1'b0;
            m_busy = 1'b0; m_phase = 1'b1; m_cnt = 0; m_prev = 1'b0;
            return;
        end
        fs = origin && !m_prev;
        if (load) begin
            p_value = value; p_color = digit_color; p_mask = blink_mask; p_lz = lz_suppress;
            m_busy = 1'b1;
        end
        if (fs) begin
            if (load || m_busy) begin
                m_value = p_value; m_color = p_color; m_mask = p_mask; m_lz = p_lz;
            end
            m_busy = 1'b0;
            if (m_cnt == BF - 1) begin
                m_cnt   = 0;
                m_phase = !m_phase;
            end else begin
                m_cnt++;
            end
        end
        m_prev = origin;
    endfunction

    // One pixel cycle: push expectation, advance a clock, score the outputs
    task automatic px(input int h, input int v, input logic [11:0] base, input bit chk);
        exp_t e;
        logic rst_now;
        h_cnt = 10'(h); v_cnt = 10'(v); base_pixel = base;
        e.h = h; e.v = v; e.chk = chk;
        if (rst) begin
            e.addr = '0; e.pix = '0;
        end else begin
            e.addr = exp_addr(h, v); e.pix = exp_pix(h, v, base);
        end
        rst_now = rst;
        sb.push_back(e);
        model_update(h, v);
        @(posedge clka); #1;
        if (sb[$].chk) begin
            n_checks++;
            if (glyph_addr !== sb[$].addr) begin
                n_fail++;
                $display("FAIL sb_addr h=%0d v=%0d: got %h expected %h", sb[$].h, sb[$].v, glyph_addr, sb[$].addr);
            end
        end
        if (sb.size() == 2) begin
            e = sb.pop_front();
            if (rst_now) e.pix = '0;
            if (e.chk) begin
                n_checks++;
                if (pixel_out !== e.pix) begin
                    n_fail++;
                    $display("FAIL sb_pixel h=%0d v=%0d: got %h expected %h", e.h, e.v, pixel_out, e.pix);
                end
            end
        end
    endtask

    task automatic frame_start();
        px(700, 500, 12'h111, 1);
        px(0, 0, 12'h222, 1);
    endtask

    task automatic do_load(input logic [15:0] val, input logic [3:0] mask, input logic lz);
        value = val; digit_color = COLORS; blink_mask = mask; lz_suppress = lz;
        load = 1'b1;
        px(5, 6, 12'h0AA, 1);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        px(X0, Y0, 12'hABC, 1);
        px(X0 + 1, Y0, 12'hABD, 1);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (pixel_out !== 12'h000) begin n_fail++; $display("FAIL reset_pixel: got %h expected 000", pixel_out); end
        n_checks++;
        if (glyph_addr !== 12'h000) begin n_fail++; $display("FAIL reset_addr: got %h expected 000", glyph_addr); end
        rst = 1'b0;
        px(5, 5, 12'h010, 1);
    endtask

    task automatic test_load_lz();
        use_hash = 1'b0; rom_const = 10'h3FF;
        px(5, 5, 12'h020, 1);
        do_load(16'h0123, 4'b0000, 1'b1);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL lz_busy_set: got %b expected 1", busy); end
        for (int k = 0; k < 3; k++) px(600, 300 + k, 12'h030, 1);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL lz_busy_hold: got %b expected 1", busy); end
        frame_start();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL lz_busy_clear: got %b expected 0", busy); end
        px(fx(0) + 4, Y0 + 4, 12'h5A5, 1); px(5, 5, 12'h000, 1);
        n_checks++;
        if (pixel_out !== 12'h5A5) begin n_fail++; $display("FAIL lz_left_blank: got %h expected 5a5", pixel_out); end
        px(fx(1) + 4, Y0 + 4, 12'h5A5, 1); px(5, 5, 12'h000, 1);
        n_checks++;
        if (pixel_out !== 12'h0F0) begin n_fail++; $display("FAIL lz_field2: got %h expected 0f0", pixel_out); end
        px(fx(3) + 9, Y0 + 30, 12'h5A5, 1); px(5, 5, 12'h000, 1);
        n_checks++;
        if (pixel_out !== 12'hFF0) begin n_fail++; $display("FAIL lz_field0: got %h expected ff0", pixel_out); end
        use_hash = 1'b1;
        for (int s = 0; s < N; s++)
            for (int k = 0; k < 6; k++)
                px(fx(s) + k * 5 + 1, Y0 + k * 6 + 1, 12'($urandom), 1);
        // field and window edges
        px(X0 - 1, Y0, 12'h101, 1);
        px(X0, Y0 - 1, 12'h102, 1);
        px(X0 + GW - 1, Y0 + GH - 1, 12'h103, 1);
        px(X0 + N * GW - 1, Y0 + 3, 12'h104, 1);
        px(X0 + N * GW, Y0 + 3, 12'h105, 1);
        px(X0 + 5, Y0 + GH, 12'h106, 1);
        px(5, 5, 12'h000, 1);
    endtask

    task automatic test_addr();
        use_hash = 1'b0; rom_const = 10'h3FF;
        do_load(16'h4567, 4'b0000, 1'b0);
        frame_start();
        px(X0, Y0, 12'h0C0, 1);
        n_checks++;
        if (glyph_addr !== 12'h000) begin n_fail++; $display("FAIL addr_origin: got %h expected 000", glyph_addr); end
        px(5, 5, 12'h000, 1);
        n_checks++;
        if (pixel_out !== 12'hF00) begin n_fail++; $display("FAIL addr_pixel: got %h expected f00", pixel_out); end
    endtask

    task automatic test_back_to_back();
        use_hash = 1'b0; rom_const = 10'b00_0000_0100;
        px(5, 5, 12'h000, 1);
        do_load(16'h1111, 4'b0000, 1'b0);
        do_load(16'h2222, 4'b0000, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_set: got %b expected 1", busy); end
        frame_start();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_clear: got %b expected 0", busy); end
        px(fx(2) + 7, Y0 + 7, 12'h444, 1); px(5, 5, 12'h000, 1);
        n_checks++;
        if (pixel_out !== 12'h00F) begin n_fail++; $display("FAIL b2b_last_wins: got %h expected 00f", pixel_out); end
    endtask

    task automatic test_bad_digit();
        logic [11:0] b;
        use_hash = 1'b0; rom_const = 10'h3FF;
        px(5, 5, 12'h000, 1);
        do_load(16'h1A23, 4'b0000, 1'b0);
        frame_start();
        for (int k = 0; k < 4; k++) begin
            b = 12'h300 + 12'(k);
            px(fx(1) + (k % 2) * (GW - 1), Y0 + (k / 2) * (GH - 1), b, 1);
            px(5, 5, 12'h000, 1);
            n_checks++;
            if (pixel_out !== b) begin n_fail++; $display("FAIL bad_digit_%0d: got %h expected %h", k, pixel_out, b); end
        end
    endtask

    task automatic test_blink();
        logic [11:0] want;
        rst = 1'b1;
        px(5, 5, 12'h000, 1);
        rst = 1'b0;
        use_hash = 1'b0; rom_const = 10'h3FF;
        px(5, 5, 12'h000, 1);
        do_load(16'h1234, 4'b0001, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            frame_start();
            px(fx(3) + 3, Y0 + 2, 12'h333, 1);
            px(5, 5, 12'h000, 1);
            want = (k == 1 || k == 4) ? 12'hFF0 : 12'h333;
            n_checks++;
            if (pixel_out !== want) begin n_fail++; $display("FAIL blink_frame%0d: got %h expected %h", k, pixel_out, want); end
        end
    endtask

    task automatic test_reset_pending();
        use_hash = 1'b0; rom_const = 10'h3FF;
        px(5, 5, 12'h000, 1);
        do_load(16'h9876, 4'b0000, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rp_busy_set: got %b expected 1", busy); end
        rst = 1'b1;
        px(5, 7, 12'h0BB, 1);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rp_busy_clear: got %b expected 0", busy); end
        n_checks++;
        if (pixel_out !== 12'h000) begin n_fail++; $display("FAIL rp_pixel_zero: got %h expected 000", pixel_out); end
        rst = 1'b0;
        px(5, 8, 12'h0BC, 1);
        frame_start();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rp_busy_after_fs: got %b expected 0", busy); end
        px(fx(3) + 5, Y0 + 5, 12'h777, 1); px(5, 5, 12'h000, 1);
        n_checks++;
        if (pixel_out !== 12'h000) begin n_fail++; $display("FAIL rp_no_commit: got %h expected 000", pixel_out); end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; h_cnt = '0; v_cnt = '0; base_pixel = '0;
        value = '0; digit_color = '0; blink_mask = '0; lz_suppress = 1'b0;
        use_hash = 1'b0; rom_const = 10'h3FF;
        m_value = '0; m_color = '0; m_mask = '0; m_lz = 1'b0;
        p_value = '0; p_color = '0; p_mask = '0; p_lz = 1'b0;
        m_busy = 1'b0; m_phase = 1'b1; m_cnt = 0; m_prev = 1'b0;
        @(negedge clka);
        test_reset();
        test_load_lz();
        test_addr();
        test_back_to_back();
        test_bad_digit();
        test_blink();
        test_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
